// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one WIDTH-bit adder between
// NREQ requesters. The granted operand pair is added and the sum is held in a
// single registered response slot, tagged with the requester index.
//
// Handshake contract (both sides): a transfer happens on the rising edge
// where valid and ready are both 1. Producers keep valid and payload stable
// until that edge. Valid never depends combinationally on ready.
// req_ready is a function of req_valid, rsp_ready and registered state only.
//
// The slot state is directly visible on rsp_valid (EMPTY=0, FULL=1).
module adder_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 3,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_carry,
    output logic [IDW-1:0]        rsp_id,
    input  logic                  rsp_ready,
    output logic                  busy
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    slot_state_e      slot_q, slot_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;

    logic             can_accept;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   cand_idx;
    logic             accept;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH:0]   sum;

    // The slot can take a new result when empty or when it drains this edge.
    always_comb begin
        can_accept = (slot_q == SLOT_EMPTY) || rsp_ready;
    end

    // Round-robin search: first valid requester after the last one granted.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_idx = IDW'((int'(last_grant_q) + k) % NREQ);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Grant is one-hot on the winner, and only when the slot can take it.
    always_comb begin
        accept    = can_accept && grant_found;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept && (grant_idx == IDW'(i));
        end
    end

    // Operand mux feeding the single shared adder; carry kept in bit WIDTH.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                op_a = req_a[i*WIDTH +: WIDTH];
                op_b = req_b[i*WIDTH +: WIDTH];
            end
        end
        sum = {1'b0, op_a} + {1'b0, op_b};
    end

    // Slot next state: accept overwrites (even while draining), a bare drain
    // only clears the valid state and leaves the payload untouched.
    always_comb begin
        slot_d       = slot_q;
        rsp_data_d   = rsp_data_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            slot_d       = SLOT_FULL;
            rsp_data_d   = sum[WIDTH-1:0];
            rsp_carry_d  = sum[WIDTH];
            rsp_id_d     = grant_idx;
            last_grant_d = grant_idx;
        end else if ((slot_q == SLOT_FULL) && rsp_ready) begin
            slot_d = SLOT_EMPTY;
        end
    end

    // State registers; last_grant resets to NREQ-1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q       <= SLOT_EMPTY;
            rsp_data_q   <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_id_q     <= '0;
            last_grant_q <= IDW'(NREQ - 1);
        end else begin
            slot_q       <= slot_d;
            rsp_data_q   <= rsp_data_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Outputs come straight from registers, except busy which also sees requests.
    always_comb begin
        rsp_valid = (slot_q == SLOT_FULL);
        rsp_data  = rsp_data_q;
        rsp_carry = rsp_carry_q;
        rsp_id    = rsp_id_q;
        busy      = rsp_valid || (|req_valid);
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: directed scenarios followed by random
// traffic, with expected responses queued at grant time and checked by an
// independent monitor whenever the response slot is observed.
module tb_adder_share_arbiter;

    localparam int WIDTH = 32;
    localparam int NREQ  = 3;
    localparam int IDW   = $clog2(NREQ);
    localparam int EW    = IDW + 1 + WIDTH;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_a     = '0;
    logic [NREQ*WIDTH-1:0] req_b     = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_carry;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_ready = 1'b0;
    logic                  busy;

    adder_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    // ---------------- scoreboard state ----------------
    int vectors     = 0;
    int miscompares = 0;
    logic [EW-1:0] exp_q[$];   // {id, carry, data}
    logic mon_en = 1'b0;

    // Requester-side view and reference model state.
    logic [NREQ-1:0]  v;
    logic [WIDTH-1:0] a_arr[NREQ];
    logic [WIDTH-1:0] b_arr[NREQ];
    logic             rr;
    int               last_g;
    bit               slot_full;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] pick_operand();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return WIDTH'($urandom_range(0, 15));
            default: return WIDTH'($urandom);
        endcase
    endfunction

    // ---------------- monitor ----------------
    // Compares the response slot against the queue head every cycle it is
    // expected full; pops when the consumer takes it on the coming edge.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check("busy", {63'd0, busy}, {63'd0, (exp_q.size() != 0) || (|v)});
            check("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                check("rsp_data", {32'd0, rsp_data}, {32'd0, exp_q[0][WIDTH-1:0]});
                check("rsp_carry", {63'd0, rsp_carry}, {63'd0, exp_q[0][WIDTH]});
                check("rsp_id", {{(64-IDW){1'b0}}, rsp_id}, {{(64-IDW){1'b0}}, exp_q[0][EW-1 -: IDW]});
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    // One clock cycle: drive current requests, check the grant against the
    // round-robin model, and on acceptance queue the expected result.
    // Entered and left 2 time units after a rising edge.
    task automatic step(output bit acc, output int g);
        int exp_g;
        int c;
        logic [NREQ-1:0] exp_rdy;
        longint s;
        req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = a_arr[i];
            req_b[i*WIDTH +: WIDTH] = b_arr[i];
        end
        rsp_ready = rr;
        @(negedge clk);
        #1;
        exp_g = -1;
        if (!slot_full || rr) begin
            for (int k = 1; k <= NREQ; k++) begin
                c = (last_g + k) % NREQ;
                if (exp_g < 0 && v[c]) exp_g = c;
            end
        end
        exp_rdy = (exp_g >= 0) ? (NREQ'(1) << exp_g) : '0;
        check("req_ready", {61'd0, req_ready}, {61'd0, exp_rdy});
        @(posedge clk);
        acc = (exp_g >= 0);
        g   = exp_g;
        if (acc) begin
            s = longint'(a_arr[g]) + longint'(b_arr[g]);
            exp_q.push_back({IDW'(g), s[WIDTH], s[WIDTH-1:0]});
            last_g    = g;
            slot_full = 1'b1;
            v[g]      = 1'b0;
        end else if (rr) begin
            slot_full = 1'b0;
        end
        #2;
    endtask

    task automatic idle(input int n);
        bit acc;
        int g;
        v  = '0;
        rr = 1'b1;
        repeat (n) step(acc, g);
    endtask

    // Asynchronous reset pulse between edges while a response is pending.
    task automatic reset_mid();
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
        check("rst_rsp_carry", {63'd0, rsp_carry}, 64'd0);
        check("rst_rsp_id", {{(64-IDW){1'b0}}, rsp_id}, 64'd0);
        exp_q.delete();
        last_g    = NREQ - 1;
        slot_full = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit acc;
        int g;
        v         = '0;
        rr        = 1'b1;
        last_g    = NREQ - 1;
        slot_full = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end

        // Reset values.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("reset_rsp_data", {32'd0, rsp_data}, 64'd0);
        check("reset_rsp_carry", {63'd0, rsp_carry}, 64'd0);
        check("reset_rsp_id", {{(64-IDW){1'b0}}, rsp_id}, 64'd0);
        check("reset_req_ready", {61'd0, req_ready}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single request from requester 1: 5 + 7.
        v = 3'b010; a_arr[1] = 32'd5; b_arr[1] = 32'd7;
        step(acc, g);
        idle(2);

        // Three-way contention, each requester leaves after its grant.
        v = 3'b111;
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = $urandom; b_arr[i] = $urandom;
        end
        repeat (3) step(acc, g);
        idle(2);

        // Wrap-around carries.
        v = 3'b001; a_arr[0] = 32'hFFFF_FFFF; b_arr[0] = 32'h0000_0002;
        step(acc, g);
        v = 3'b001; a_arr[0] = 32'h8000_0000; b_arr[0] = 32'h8000_0000;
        step(acc, g);
        idle(2);

        // Back-pressure: slot holds 0x10 for 4 stalled cycles, then req 2 wins.
        v = 3'b001; a_arr[0] = 32'h8; b_arr[0] = 32'h8;
        step(acc, g);
        rr = 1'b0;
        v = 3'b100; a_arr[2] = 32'h123; b_arr[2] = 32'h456;
        repeat (4) step(acc, g);
        rr = 1'b1;
        step(acc, g);
        idle(2);

        // Fairness: requester 0 always valid, requester 2 re-raises after grant.
        v = 3'b101; rr = 1'b1;
        for (int n = 0; n < 8; n++) begin
            step(acc, g);
            for (int i = 0; i < NREQ; i += 2) begin
                if (!v[i]) begin
                    v[i] = 1'b1; a_arr[i] = pick_operand(); b_arr[i] = pick_operand();
                end
            end
        end
        idle(2);

        // Reset while a stalled response is pending; then req 1 wins first.
        v = 3'b001; a_arr[0] = 32'h33; b_arr[0] = 32'h44; rr = 1'b1;
        step(acc, g);
        v = '0; rr = 1'b0;
        step(acc, g);
        reset_mid();
        v = 3'b110; rr = 1'b1;
        a_arr[1] = 32'h10; b_arr[1] = 32'h20; a_arr[2] = 32'h1; b_arr[2] = 32'h2;
        step(acc, g);
        idle(3);

        // Random traffic.
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i] && $urandom_range(0, 2) == 0) begin
                    v[i] = 1'b1; a_arr[i] = pick_operand(); b_arr[i] = pick_operand();
                end
            end
            rr = ($urandom_range(0, 3) != 0);
            step(acc, g);
        end

        // Drain everything and confirm nothing is left outstanding.
        idle(4);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
